// File: rtl/flappy_button_mmio.sv
// Push-button responder on the data-memory bus: sync, debounce, press events,
// flap counter and a four-word register window.
module flappy_button_mmio #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20,
   parameter logic [11:0] BASE_ADDR       = 12'hFF0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        up,
   input  logic        down,
   input  logic        right,
   input  logic        left,
   input  logic        wren,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   output logic        io_hit,
   output logic [31:0] q_io,
   output logic        flap_pulse
);

   localparam int unsigned NBTN = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NBTN-1:0]            raw;
   logic [NBTN-1:0]            sync_a;
   logic [NBTN-1:0]            sync_b;
   logic [NBTN-1:0]            deb;
   logic [NBTN-1:0]            deb_q;
   logic [NBTN-1:0]            rise;
   logic [NBTN-1:0][CNT_W-1:0] cnt;
   logic [NBTN-1:0]            events;
   logic [NBTN-1:0]            ev_clr;
   logic [15:0]                press_count;
   logic                       ctrl;
   logic [1:0]                 off;
   logic                       wr_hit;
   logic [31:0]                rd_data;
   logic                       unused_data;

   // Button order {left,right,down,up} matches register bit order [3:0].
   assign raw         = {left, right, down, up};
   assign rise        = deb & ~deb_q;
   assign io_hit      = (address_dmem[11:2] == BASE_ADDR[11:2]);
   assign off         = 2'(address_dmem - BASE_ADDR);
   assign wr_hit      = wren & io_hit;
   assign ev_clr      = (wr_hit && off == 2'd1) ? data[NBTN-1:0] : '0;
   assign unused_data = ^data[31:16];

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Per-button debounce: level follows sync only after an unbroken run of differing cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         deb <= '0;
         cnt <= '0;
      end else begin
         for (int i = 0; i < NBTN; i++) begin
            if (sync_b[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync_b[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Edge-detect history and the flap pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         deb_q      <= '0;
         flap_pulse <= 1'b0;
      end else begin
         deb_q      <= deb;
         flap_pulse <= rise[0];
      end
   end

   // Sticky events (set beats clear) and the event-enable control bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         events <= '0;
         ctrl   <= 1'b1;
      end else begin
         events <= (events & ~ev_clr) | (rise & {NBTN{ctrl}});
         if (wr_hit && off == 2'd3) begin
            ctrl <= data[0];
         end
      end
   end

   // Flap counter; a store in the same cycle as an up rise overrides the increment.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         press_count <= '0;
      end else if (wr_hit && off == 2'd2) begin
         press_count <= data[15:0];
      end else if (rise[0]) begin
         press_count <= press_count + 16'd1;
      end
   end

   // Read-data select from pre-update register values.
   always_comb begin
      rd_data = '0;
      if (io_hit) begin
         case (off)
            2'd0:    rd_data = {28'd0, deb};
            2'd1:    rd_data = {28'd0, events};
            2'd2:    rd_data = {16'd0, press_count};
            default: rd_data = {31'd0, ctrl};
         endcase
      end
   end

   // Registered load data, one cycle after the address.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_io <= '0;
      end else begin
         q_io <= rd_data;
      end
   end

endmodule

// File: tb/tb_flappy_button_mmio.sv
// Bench for flappy_button_mmio with a short debounce window.
module tb_flappy_button_mmio;

   logic        clk;
   logic        rst_n;
   logic        up, down, right, left;
   logic        wren;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        io_hit;
   logic [31:0] q_io;
   logic        flap_pulse;

   flappy_button_mmio #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(20),
      .BASE_ADDR(12'hFF0)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .up(up),
      .down(down),
      .right(right),
      .left(left),
      .wren(wren),
      .address_dmem(address_dmem),
      .data(data),
      .io_hit(io_hit),
      .q_io(q_io),
      .flap_pulse(flap_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        chk;
      logic [31:0] exp;
      string       nm;
   } sb_t;

   typedef struct {
      logic [11:0] addr;
      logic        wr;
      logic [31:0] d;
      logic        hit;
      logic [31:0] q;
   } vec_t;

   sb_t  sb[$];
   sb_t  e;
   vec_t vec[17];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   n_flap = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One bus cycle: drive at negedge, queue the q_io expected after the next posedge.
   task automatic cyc(input logic [11:0] a, input logic w, input logic [31:0] d,
                      input logic c, input logic [31:0] x, input string nm);
      address_dmem = a;
      wren         = w;
      data         = d;
      sb.push_back('{c, x, nm});
      @(negedge clk);
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] x, input string nm);
      cyc(a, 1'b0, 32'h0, 1'b1, x, nm);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      cyc(a, 1'b1, d, 1'b0, 32'h0, "wr");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(12'h000, 1'b0, 32'h0, 1'b0, 32'h0, "idle");
   endtask

   // Scoreboard pop and flap-pulse counting, just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (flap_pulse === 1'b1) n_flap++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk) check(e.nm, q_io, e.exp);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not end, expected finish");
      $fatal(1);
   end

   initial begin
      vec[0]  = '{12'hFEF, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
      vec[1]  = '{12'hFF4, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
      vec[2]  = '{12'hFF0, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
      vec[3]  = '{12'hFF1, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
      vec[4]  = '{12'hFF2, 1'b0, 32'h0,         1'b1, 32'h0000_1234};
      vec[5]  = '{12'hFF3, 1'b0, 32'h0,         1'b1, 32'h0000_0001};
      vec[6]  = '{12'hFF3, 1'b1, 32'h0,         1'b1, 32'h0000_0001};
      vec[7]  = '{12'hFF3, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
      vec[8]  = '{12'hFF2, 1'b1, 32'h0000_ABCD, 1'b1, 32'h0000_1234};
      vec[9]  = '{12'hFF2, 1'b0, 32'h0,         1'b1, 32'h0000_ABCD};
      vec[10] = '{12'hFF3, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
      vec[11] = '{12'hFF3, 1'b0, 32'h0,         1'b1, 32'h0000_0001};
      vec[12] = '{12'hFF2, 1'b1, 32'hFFFF_0007, 1'b1, 32'h0000_ABCD};
      vec[13] = '{12'hFF2, 1'b0, 32'h0,         1'b1, 32'h0000_0007};
      vec[14] = '{12'h000, 1'b0, 32'h0,         1'b0, 32'h0000_0000};
      vec[15] = '{12'hFF0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
      vec[16] = '{12'hFF0, 1'b0, 32'h0,         1'b1, 32'h0000_0000};

      rst_n = 1'b1;
      up = 1'b0; down = 1'b0; right = 1'b0; left = 1'b0;
      wren = 1'b0; address_dmem = 12'h000; data = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      check("por_q_io", q_io, 32'h0);
      check("por_flap", 32'(flap_pulse), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset values of the register window.
      rd(12'hFF0, 32'h0, "rst_status");
      rd(12'hFF1, 32'h0, "rst_events");
      rd(12'hFF2, 32'h0, "rst_count");
      rd(12'hFF3, 32'h1, "rst_ctrl");

      // Reset asserted mid-count with up held.
      wr(12'hFF3, 32'h0);
      wr(12'hFF2, 32'h5);
      rd(12'hFF2, 32'h5, "pre_count");
      up = 1'b1;
      for (int i = 0; i < 4; i++) rd(12'hFF2, 32'h5, "midcount_count");
      #2 rst_n = 1'b0;
      #1;
      check("async_q_io", q_io, 32'h0);
      check("async_flap", 32'(flap_pulse), 32'h0);
      @(negedge clk);
      rd(12'hFF2, 32'h0, "held_rst_q");
      rd(12'hFF2, 32'h0, "held_rst_q");
      rst_n = 1'b1;
      rd(12'hFF3, 32'h1, "post_rst_ctrl");
      rd(12'hFF1, 32'h0, "post_rst_events");
      rd(12'hFF2, 32'h0, "post_rst_count");
      rd(12'hFF0, 32'h0, "status_e4");
      rd(12'hFF0, 32'h0, "status_e5");
      rd(12'hFF0, 32'h0, "status_e6");
      rd(12'hFF0, 32'h1, "status_e7");
      rd(12'hFF1, 32'h1, "press_events");
      rd(12'hFF2, 32'h1, "press_count");
      check("flaps_t1", 32'(n_flap), 32'd1);
      up = 1'b0;
      idle(10);

      // Bounce on up yields a single press.
      wr(12'hFF2, 32'h0);
      wr(12'hFF1, 32'hF);
      rd(12'hFF1, 32'h0, "cleared_events");
      up = 1'b1; idle(1);
      up = 1'b0; idle(1);
      up = 1'b1; idle(12);
      rd(12'hFF0, 32'h1, "bounce_status");
      rd(12'hFF1, 32'h1, "bounce_events");
      rd(12'hFF2, 32'h1, "bounce_count");
      check("flaps_t2", 32'(n_flap), 32'd2);
      up = 1'b0;
      idle(10);

      // W1C store in the same edge as an up rise: set wins.
      up = 1'b1;
      idle(6);
      wr(12'hFF1, 32'h1);
      rd(12'hFF1, 32'h1, "w1c_race_events");
      rd(12'hFF2, 32'h2, "w1c_race_count");
      check("flaps_t3", 32'(n_flap), 32'd3);
      wr(12'hFF1, 32'hF);
      rd(12'hFF1, 32'h0, "w1c_clear");
      up = 1'b0;
      idle(10);

      // Event enable off: levels and count still track, events do not.
      wr(12'hFF3, 32'h0);
      rd(12'hFF3, 32'h0, "ctrl_off");
      down = 1'b1;
      idle(10);
      rd(12'hFF1, 32'h0, "dis_events_down");
      rd(12'hFF0, 32'h2, "dis_status_down");
      up = 1'b1;
      idle(10);
      rd(12'hFF0, 32'h3, "dis_status_both");
      rd(12'hFF2, 32'h3, "dis_count");
      rd(12'hFF1, 32'h0, "dis_events_up");
      check("flaps_t4", 32'(n_flap), 32'd4);
      up = 1'b0; down = 1'b0;
      idle(10);
      wr(12'hFF3, 32'h1);
      right = 1'b1; left = 1'b1;
      idle(10);
      rd(12'hFF1, 32'hC, "en_events_rl");
      rd(12'hFF0, 32'hC, "en_status_rl");
      right = 1'b0; left = 1'b0;
      idle(10);
      wr(12'hFF1, 32'hF);

      // Counter wrap, store-vs-rise override, and plain load.
      wr(12'hFF2, 32'h0000_FFFF);
      up = 1'b1;
      idle(10);
      rd(12'hFF2, 32'h0, "count_wrap");
      check("flaps_t5", 32'(n_flap), 32'd5);
      up = 1'b0;
      idle(10);
      up = 1'b1;
      idle(6);
      wr(12'hFF2, 32'h0000_0055);
      rd(12'hFF2, 32'h55, "count_store_race");
      up = 1'b0;
      idle(10);
      wr(12'hFF2, 32'h0000_1234);
      rd(12'hFF2, 32'h1234, "count_load");
      wr(12'hFF1, 32'hF);

      // Decode and register access table.
      for (int i = 0; i < 17; i++) begin
         address_dmem = vec[i].addr;
         wren         = vec[i].wr;
         data         = vec[i].d;
         #1;
         check($sformatf("tbl_hit[%0d]", i), 32'(io_hit), 32'(vec[i].hit));
         sb.push_back('{1'b1, vec[i].q, $sformatf("tbl_q[%0d]", i)});
         @(negedge clk);
      end
      idle(2);
      check("flaps_final", 32'(n_flap), 32'd6);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
